wb_stage: RTL
=============

# wb_stage

Parametrised writeback stage for the pipelined RISC-V core. It selects among four result sources and extracts and extends sub-word load data. It waits on a variable-latency memory read response, stalling the pipeline when necessary. It drives a registered register-file write port and keeps a retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, datapath width; must be 32 (byte/half lane logic assumes 4 lanes)
- REG_AW, 5, register address width
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- valid_w  in  1  instruction present in WB this cycle
- alu_result_w  in  XLEN  ALU result; bits [1:0] are the load byte offset
- pc_plus4_w  in  XLEN  PC+4 (JAL/JALR link)
- imm_ext_w  in  XLEN  extended immediate (LUI)
- result_src_w  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate
- funct3_w  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- reg_write_w  in  1  instruction writes rd
- rd_w  in  REG_AW  destination register
- rdata_valid  in  1  memory read data valid this cycle
- rdata  in  XLEN  raw aligned word from data memory
- stall_w  out  1  WB cannot retire; upstream holds all WB inputs
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  REG_AW  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data / forwarding value (registered)
- retire  out  1  one-cycle pulse per retired instruction (registered)
- instret  out  CNT_W  retired-instruction count

## Operation
- Result mux selects on result_src_w:
  - 00: alu_result_w
  - 01: load-extracted data
  - 10: pc_plus4_w
  - 11: imm_ext_w
- Load extraction uses off = alu_result_w[1:0]:
  - LB: rdata[8*off+7 : 8*off], sign-extended.
  - LBU: same byte, zero-extended.
  - LH: halfword at alu_result_w[1] (bit 0 ignored), sign-extended.
  - LHU: same halfword, zero-extended.
  - LW and all other funct3 codes: full word.
- FSM has two states, IDLE and WAIT.
  - IDLE, valid_w=1, result_src_w=01, rdata_valid=0: go to WAIT; stall_w=1.
  - IDLE, valid_w=1, and either not a load or rdata_valid=1: instruction retires this cycle; stall_w=0.
  - WAIT, rdata_valid=0: stay in WAIT; stall_w=1.
  - WAIT, rdata_valid=1: retire; stall_w=0; return to IDLE.
- stall_w is combinational from state, valid_w, result_src_w and rdata_valid.
- Upstream holds all WB inputs stable while stall_w=1.
- rdata_valid while no load is pending (IDLE, non-load or valid_w=0) is ignored.
- Retire cycle effects, taking effect at the next edge:
  - retire=1.
  - rf_we = reg_write_w & (rd_w != 0); x0 is never written.
  - rf_waddr=rd_w and rf_wdata=selected result.
  - instret increments.
- Non-retire cycles: rf_we=0 and retire=0 at the next edge; rf_waddr and rf_wdata hold their last values.
- An instruction with reg_write_w=0 still retires and counts.
- instret wraps from 2^CNT_W-1 to 0 without flagging.

## Timing
- Reset values: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, retire=0, instret=0.
- stall_w is 0 during reset.
- Non-load, or load with rdata_valid already high: zero stall cycles. rf_we and retire are high one cycle after valid_w.
- Load with a memory response N cycles late: stall_w is high for N cycles. The write appears on the edge after the rdata_valid cycle.
- Back-to-back retiring instructions give continuous rf_we/retire pulses, one per cycle.
- Reset asserted in WAIT: the pending load is dropped, no write occurs, and the counter clears immediately (asynchronous).
- Reset deassertion takes effect at the first clk edge after reset_n rises.

## Test plan
- ALU op: valid_w=1, src=00, alu=0x0000_1234, rd=5, reg_write=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retire=1, instret=1, stall_w never high.
- Sub-word loads, rdata=0x80FF_7F81, rdata_valid=1, each with rf_we the next cycle:
  - LB off=0 -> 0xFFFF_FF81
  - LBU off=1 -> 0x0000_007F
  - LH off=2 -> 0xFFFF_80FF
  - LHU off=2 -> 0x0000_80FF
- Late load: LW issued with rdata_valid=0 for 3 cycles, then 1 with rdata=0xDEAD_BEEF -> stall_w high exactly 3 cycles; rf_wdata=0xDEAD_BEEF one cycle after the valid cycle; instret +1 only.
- x0 and no-write: JAL src=10, pc_plus4=0x104 with rd=0 -> rf_we=0, retire=1. A store with reg_write=0 -> rf_we=0, instret increments.
- Reset mid-WAIT: drop reset_n during a stalled load -> all outputs 0 immediately. After release, a late rdata_valid causes no write.
- Counter wrap: CNT_W=4, 17 retiring instructions -> instret reads 1.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: result select, sub-word load extraction, load-response wait FSM,
// registered register-file write port and retired-instruction counter.
//   state  | meaning
//   S_IDLE | no load pending; retire immediately unless a load lacks its data
//   S_WAIT | load held in WB, stalling until rdata_valid
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_w,
    input  logic [XLEN-1:0]   alu_result_w,
    input  logic [XLEN-1:0]   pc_plus4_w,
    input  logic [XLEN-1:0]   imm_ext_w,
    input  logic [1:0]        result_src_w,
    input  logic [2:0]        funct3_w,
    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              rdata_valid,
    input  logic [XLEN-1:0]   rdata,
    output logic              stall_w,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              retire,
    output logic [CNT_W-1:0]  instret
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_is_load;
    logic               w_retire;
    logic               w_stall;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [XLEN-1:0]    w_load;
    logic [XLEN-1:0]    w_result;
    logic               r_rf_we;
    logic [REG_AW-1:0]  r_rf_waddr;
    logic [XLEN-1:0]    r_rf_wdata;
    logic               r_retire;
    logic [CNT_W-1:0]   r_instret;

    assign w_is_load = (result_src_w == 2'b01);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_w) begin
                    if (w_is_load && !rdata_valid) begin
                        w_state_nxt = S_WAIT;
                        w_stall     = 1'b1;
                    end else begin
                        w_retire = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (rdata_valid) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Held low in reset so upstream is never frozen by a pipeline that is being cleared.
    assign stall_w = w_stall & reset_n;

    always_comb begin
        w_byte = rdata[7:0];
        case (alu_result_w[1:0])
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
    end

    assign w_half = alu_result_w[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        w_load = rdata;
        case (funct3_w)
            3'b000: w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001: w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100: w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b101: w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = rdata;
        endcase
    end

    always_comb begin
        w_result = alu_result_w;
        case (result_src_w)
            2'b00: w_result = alu_result_w;
            2'b01: w_result = w_load;
            2'b10: w_result = pc_plus4_w;
            2'b11: w_result = imm_ext_w;
            default: w_result = alu_result_w;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_retire   <= 1'b0;
            r_instret  <= '0;
        end else begin
            r_retire <= w_retire;
            r_rf_we  <= w_retire & reg_write_w & (rd_w != '0);
            if (w_retire) begin
                r_rf_waddr <= rd_w;
                r_rf_wdata <= w_result;
                r_instret  <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign retire   = r_retire;
    assign instret  = r_instret;

endmodule
